upsample2x_stream: RTL and testbench

- Streaming 2x nearest-neighbour upsampler for the YOLO neck. It is the inverse of the max-pool stage: pooling shrinks H×W, this block expands it.
- Input: an H×W frame of FP16 pixels in raster order, with all D channels of one pixel packed in one word.
- Output: a 2H×2W frame, with every pixel duplicated horizontally and every row duplicated vertically.
- Sits between a backbone feature-map reader and the concat/route stage; valid/ready on both sides.

---
 rtl/upsample_pkg.sv | 20 ++
 rtl/upsample_line_buf.sv | 27 ++
 rtl/upsample2x_stream.sv | 188 ++++++++++++++++++
 tb/tb_upsample2x_stream.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upsample_pkg.sv
// Shared types and helpers for the 2x nearest-neighbour upsampler.
package upsample_pkg;

  typedef enum logic {
    ROW_A,  // stream-through of the current input row
    ROW_B   // replay of the buffered row
  } state_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_D          = 2;

  // Channel 0 sits at bit 0, the MSB end of the word.
  typedef logic [0:DEF_D*DEF_DATA_WIDTH-1] pix_word_t;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/upsample_line_buf.sv
// One-row pixel buffer: synchronous write, combinational read.
module upsample_line_buf
  import upsample_pkg::*;
#(
  parameter int DEPTH = 9,
  parameter int WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        we_i,
  input  logic [cnt_width(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]            wdata_i,
  input  logic [cnt_width(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]            rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Capture each pixel of the row as it streams through.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/upsample2x_stream.sv
// Streaming 2x nearest-neighbour upsampler (H x W in, 2H x 2W out).
// Optional frame-level pass-through selected by macro UPSAMPLE_BYPASS_EN.
module upsample2x_stream
  import upsample_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int D          = DEF_D,
  parameter int H          = 9,
  parameter int W          = 9
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef UPSAMPLE_BYPASS_EN
  input  logic                    bypass,
`endif
  input  logic [0:D*DATA_WIDTH-1] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [0:D*DATA_WIDTH-1] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int WORD = D * DATA_WIDTH;
  localparam int CW   = cnt_width(W);
  localparam int RW   = cnt_width(H);
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            dup_q, dup_d;
  logic            out_valid_q, out_valid_d;
  logic [0:WORD-1] out_data_q, out_data_d;

  logic            in_ready_c;
  logic            in_beat, out_beat, col_end, row_end;
  logic            byp;

  logic            lb_we;
  logic [CW-1:0]   lb_waddr, lb_raddr;
  logic [WORD-1:0] lb_rdata;

`ifdef UPSAMPLE_BYPASS_EN
  logic bypass_q;
  logic idle;
  // The mode input is only honoured between frames; mid-frame the latch holds.
  assign idle = (state_q == ROW_A) && (row_q == '0) && (col_q == '0) && !out_valid_q;
  assign byp  = idle ? bypass : bypass_q;
`else
  assign byp  = 1'b0;
`endif

  upsample_line_buf #(
    .DEPTH (W),
    .WIDTH (WORD)
  ) u_lbuf (
    .clk_i   (clk),
    .we_i    (lb_we),
    .waddr_i (lb_waddr),
    .wdata_i (in_data),
    .raddr_i (lb_raddr),
    .rdata_o (lb_rdata)
  );

  assign col_end = (col_q == COL_LAST);
  assign row_end = (row_q == ROW_LAST);
  assign out_beat = out_valid_q && out_ready;

  // Next-state for FSM, counters, output register and line-buffer ports.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    dup_d       = dup_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    in_ready_c  = 1'b0;
    in_beat     = 1'b0;
    lb_we       = 1'b0;
    lb_waddr    = col_q;
    lb_raddr    = '0;

    if (byp) begin
      in_ready_c = !out_valid_q || out_ready;
      in_beat    = in_valid && in_ready_c;
      if (out_beat) begin
        out_valid_d = 1'b0;
        if (col_end) begin
          col_d = '0;
          row_d = row_end ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      if (in_beat) begin
        out_data_d  = in_data;
        out_valid_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ROW_A: begin
          // The last column's second copy hands over to the replay row,
          // so no new pixel may be taken on that beat.
          in_ready_c = !out_valid_q || (out_ready && dup_q && !col_end);
          in_beat    = in_valid && in_ready_c;
          if (out_beat) begin
            if (!dup_q) begin
              dup_d = 1'b1;
            end else if (col_end) begin
              state_d     = ROW_B;
              col_d       = '0;
              out_data_d  = lb_rdata;
              out_valid_d = 1'b1;
              dup_d       = 1'b0;
            end else begin
              col_d       = col_q + 1'b1;
              out_valid_d = 1'b0;
            end
          end
          if (in_beat) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
            dup_d       = 1'b0;
            lb_we       = 1'b1;
            // With a word still presented, col advances on this same edge.
            lb_waddr    = out_valid_q ? col_q + 1'b1 : col_q;
          end
        end
        ROW_B: begin
          lb_raddr = col_q + 1'b1;
          if (out_beat) begin
            if (!dup_q) begin
              dup_d = 1'b1;
            end else if (col_end) begin
              state_d     = ROW_A;
              out_valid_d = 1'b0;
              col_d       = '0;
              dup_d       = 1'b0;
              row_d       = row_end ? '0 : row_q + 1'b1;
            end else begin
              col_d      = col_q + 1'b1;
              out_data_d = lb_rdata;
              dup_d      = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Register all state; synchronous reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ROW_A;
      col_q       <= '0;
      row_q       <= '0;
      dup_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef UPSAMPLE_BYPASS_EN
      bypass_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      dup_q       <= dup_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef UPSAMPLE_BYPASS_EN
      if (idle) begin
        bypass_q <= bypass;
      end
`endif
    end
  end

  assign in_ready  = in_ready_c && !reset;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = byp ? (out_valid_q && row_end && col_end)
                         : (out_valid_q && (state_q == ROW_B) && row_end && col_end && dup_q);

endmodule

// File: tb/tb_upsample2x_stream.sv
// Scoreboard bench for upsample2x_stream: a 2x2 and a 9x9 instance.
module tb_upsample2x_stream;

  localparam int DW = 16;
  localparam int DD = 2;
  localparam int WD = DW * DD;
  localparam int HS = 2, WS = 2, HB = 9, WB = 9;

  typedef logic [WD-1:0] word_t;
  typedef word_t wq_t[$];
  typedef struct packed { logic [WD-1:0] data; logic last; } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [0:WD-1] in_data [2];
  logic          in_valid[2];
  logic          in_ready[2];
  logic [0:WD-1] out_data[2];
  logic          out_valid[2];
  logic          out_ready[2];
  logic          out_last[2];

  upsample2x_stream #(.DATA_WIDTH(DW), .D(DD), .H(HS), .W(WS)) u_small (
    .clk(clk), .reset(reset),
`ifdef UPSAMPLE_BYPASS_EN
    .bypass(1'b0),
`endif
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_last(out_last[0])
  );

  upsample2x_stream #(.DATA_WIDTH(DW), .D(DD), .H(HB), .W(WB)) u_big (
    .clk(clk), .reset(reset),
`ifdef UPSAMPLE_BYPASS_EN
    .bypass(1'b0),
`endif
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_last(out_last[1])
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_mode = 0;   // 0: always ready, 1: toggling, 2: random
  beat_t exp0[$];
  beat_t exp1[$];
  int beats[2];
  int n4500;
  int acc_log[$];
  int last_log[$];
  int last_beat_log[$];
  logic  stalled[2];
  word_t held[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic int wid(input int idx);
    return (idx == 0) ? WS : WB;
  endfunction

  // Reference: each input row becomes two output rows, each pixel two beats.
  task automatic push_exp(input int idx, input wq_t pix);
    int h = (idx == 0) ? HS : HB;
    int w = wid(idx);
    for (int r = 0; r < h; r++)
      for (int rep = 0; rep < 2; rep++)
        for (int c = 0; c < w; c++)
          for (int k = 0; k < 2; k++) begin
            beat_t b;
            b.data = pix[r*w + c];
            b.last = (r == h-1) && (rep == 1) && (c == w-1) && (k == 1);
            if (idx == 0) exp0.push_back(b); else exp1.push_back(b);
          end
  endtask

  // Monitor: compare every output beat against the scoreboard queue.
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      stalled[0] = 1'b0;
      stalled[1] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (stalled[i]) begin
          check("stall_valid", out_valid[i], 1);
          check("stall_data", out_data[i], held[i]);
        end
        if (out_valid[i] && ((beats[i] % (4*wid(i))) >= 2*wid(i)))
          check("in_ready_replay_row", in_ready[i], 0);
        if (out_valid[i] && out_ready[i]) begin
          if (((i == 0) ? exp0.size() : exp1.size()) == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat dut%0d: got %0h, expected no beat", i, out_data[i]);
          end else begin
            if (i == 0) e = exp0.pop_front(); else e = exp1.pop_front();
            check("out_data", out_data[i], e.data);
            check("out_last", out_last[i], e.last);
          end
          beats[i]++;
          if (i == 0 && out_last[i]) begin
            last_log.push_back(cyc);
            last_beat_log.push_back(beats[i]);
          end
          if (i == 1 && out_data[i] == 32'h45004500) n4500++;
          stalled[i] = 1'b0;
        end else if (out_valid[i]) begin
          stalled[i] = 1'b1;
          held[i] = out_data[i];
        end else begin
          stalled[i] = 1'b0;
        end
      end
    end
  end

  // Downstream ready pattern.
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        case (rdy_mode)
          0: out_ready[i] = 1'b1;
          1: out_ready[i] = !out_ready[i];
          default: out_ready[i] = 1'($urandom_range(1));
        endcase
      end
    end
  end

  // Upstream: hold each word until accepted; random idle gaps between words.
  task automatic send_frame(input int idx, input wq_t pix, input int gap_pct);
    int k = 0;
    int budget = 0;
    logic acc;
    while (k < pix.size()) begin
      if (budget > 20000) begin
        checks++; errors++;
        $display("FAIL send_timeout dut%0d: got %0d words accepted, expected %0d", idx, k, pix.size());
        break;
      end
      in_data[idx] = pix[k];
      if (!in_valid[idx]) in_valid[idx] = ($urandom_range(99) >= gap_pct);
      @(negedge clk);
      acc = in_valid[idx] && in_ready[idx];
      if (acc) acc_log.push_back(cyc);
      @(posedge clk); #1;
      if (acc) begin
        if (k == 0) check("first_out_latency", out_valid[idx], 1);
        k++;
        in_valid[idx] = 1'b0;
        if (gap_pct == 0 && k < pix.size()) in_valid[idx] = 1'b1;
      end
      budget++;
    end
    in_valid[idx] = 1'b0;
  endtask

  task automatic wait_drain(input int idx);
    int n = 0;
    while (n < 4000) begin
      @(negedge clk);
      if ((((idx == 0) ? exp0.size() : exp1.size()) == 0) && !out_valid[idx]) break;
      n++;
    end
    if (n >= 4000) begin
      checks++; errors++;
      $display("FAIL drain_timeout dut%0d: got %0d beats outstanding, expected 0", idx,
               (idx == 0) ? exp0.size() : exp1.size());
    end
    @(posedge clk); #1;
  endtask

  function automatic wq_t basic();
    wq_t q;
    q.push_back(32'h40004000);
    q.push_back(32'h42004200);
    q.push_back(32'h45004500);
    q.push_back(32'h3C003C00);
    return q;
  endfunction

  initial begin
    wq_t b, p, two;
    int base;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b1;
      beats[i] = 0; stalled[i] = 1'b0;
    end
    n4500 = 0;
    b = basic();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_out_valid", out_valid[i], 0);
      check("reset_out_last", out_last[i], 0);
      check("reset_in_ready", in_ready[i], 0);
      check("reset_out_data", out_data[i], 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic 2x2 frame, always ready.
    last_beat_log.delete();
    base = beats[0];
    push_exp(0, b);
    send_frame(0, b, 0);
    wait_drain(0);
    check("basic_beats", beats[0] - base, 16);
    check("basic_last_count", last_beat_log.size(), 1);

    // Same frame with toggling backpressure.
    rdy_mode = 1;
    push_exp(0, b);
    send_frame(0, b, 0);
    wait_drain(0);
    rdy_mode = 0;

    // 9x9 frame with a single marked pixel at (4,4), random ready.
    p.delete();
    for (int i = 0; i < HB*WB; i++) p.push_back((i == 4*WB + 4) ? 32'h45004500 : 32'h40004000);
    rdy_mode = 2;
    base = beats[1];
    n4500 = 0;
    push_exp(1, p);
    send_frame(1, p, 20);
    wait_drain(1);
    check("big_beats", beats[1] - base, 4*HB*WB);
    check("big_marked_beats", n4500, 4);
    rdy_mode = 0;

    // Mid-frame reset after five input beats, then a clean basic frame.
    p = basic();
    p.push_back(32'h11111111);
    push_exp(0, b);
    for (int k = 0; k < 2; k++) exp0.push_back({32'h11111111, 1'b0});
    send_frame(0, p, 0);
    reset = 1'b1;
    exp0.delete(); exp1.delete();
    beats[0] = 0; beats[1] = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_valid", out_valid[0], 0);
    @(posedge clk); #1;
    base = beats[0];
    push_exp(0, b);
    send_frame(0, b, 0);
    wait_drain(0);
    check("post_reset_beats", beats[0] - base, 16);

    // Back-to-back frames with valid held high.
    acc_log.delete(); last_log.delete(); last_beat_log.delete();
    two = basic();
    for (int k = 0; k < 4; k++) two.push_back(b[k]);
    push_exp(0, b);
    push_exp(0, b);
    send_frame(0, two, 0);
    wait_drain(0);
    check("b2b_last_count", last_log.size(), 2);
    if (last_log.size() == 2 && acc_log.size() == 8) begin
      check("b2b_restart_cycle", acc_log[4], last_log[0] + 1);
      check("b2b_last_spacing", last_beat_log[1] - last_beat_log[0], 16);
    end else begin
      checks++; errors++;
      $display("FAIL b2b_logs: got %0d accepts %0d lasts, expected 8 and 2", acc_log.size(), last_log.size());
    end

    // Random frames on both instances.
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) begin
      p.delete();
      for (int i = 0; i < HS*WS; i++) p.push_back($urandom);
      push_exp(0, p);
      send_frame(0, p, 30);
    end
    wait_drain(0);
    for (int f = 0; f < 2; f++) begin
      p.delete();
      for (int i = 0; i < HB*WB; i++) p.push_back($urandom);
      push_exp(1, p);
      send_frame(1, p, 25);
    end
    wait_drain(1);
    rdy_mode = 0;

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
